// File: rtl/dich00_led_shifter.sv
// dich00_led_shifter: free-running 8-LED pattern generator.
// A clock divider produces one step tick every STEP_CYCLES clocks. Each tick
// emits the next element of a 32-step sequence made of four 8-step phases:
// run-left, run-right, fill and drain. The sequence then wraps.
module dich00_led_shifter #(
    parameter int STEP_CYCLES = 4,
    parameter bit LED_INV     = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] led
);

    // The divider needs at least one bit, even when every clock is a step.
    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN_L = 2'd0,
        RUN_R = 2'd1,
        FILL  = 2'd2,
        DRAIN = 2'd3
    } phase_t;

    logic [CW-1:0] divider;
    logic [CW-1:0] divider_nxt;
    phase_t        phase;
    phase_t        phase_nxt;
    logic [2:0]    index;
    logic [2:0]    index_nxt;
    logic [7:0]    pattern;
    logic [7:0]    pattern_nxt;
    logic [7:0]    step_value;
    logic          tick;

    // Sequence element selected by the current phase and step index.
    always_comb begin
        step_value = 8'h00;
        case (phase)
            RUN_L:   step_value = 8'h01 << index;
            RUN_R:   step_value = 8'h80 >> index;
            FILL:    step_value = ~(8'hFE << index);
            DRAIN:   step_value = 8'hFE << index;
            default: step_value = 8'h00;
        endcase
    end

    // Divider wrap, pattern load and phase/index advance on each tick.
    always_comb begin
        tick        = (divider == DIV_LAST);
        divider_nxt = divider + CW'(1);
        phase_nxt   = phase;
        index_nxt   = index;
        pattern_nxt = pattern;
        if (tick) begin
            divider_nxt = '0;
            pattern_nxt = step_value;
            index_nxt   = index + 3'd1;
            if (index == 3'd7) begin
                case (phase)
                    RUN_L:   phase_nxt = RUN_R;
                    RUN_R:   phase_nxt = FILL;
                    FILL:    phase_nxt = DRAIN;
                    DRAIN:   phase_nxt = RUN_L;
                    default: phase_nxt = RUN_L;
                endcase
            end
        end
    end

    // State registers; reset clears everything at once, even mid-step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divider <= '0;
            phase   <= RUN_L;
            index   <= 3'd0;
            pattern <= 8'h00;
        end else begin
            divider <= divider_nxt;
            phase   <= phase_nxt;
            index   <= index_nxt;
            pattern <= pattern_nxt;
        end
    end

    // Active-low LED boards get the inverted pattern.
    assign led = LED_INV ? ~pattern : pattern;

endmodule

// File: tb/tb_dich00_led_shifter.sv
// Testbench for dich00_led_shifter: three parameterisations share one clock
// and reset, and are compared every cycle against a tick-count model.
module tb_dich00_led_shifter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] led4;
    logic [7:0] led1;
    logic [7:0] led3;

    int checkCount = 0;
    int errorCount = 0;
    int edgeCount = 0;
    bit checkEnable = 1'b0;

    logic [7:0] refTable [0:31];

    logic [7:0] seqLit [0:32] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
        8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
        8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
        8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00,
        8'h01
    };

    logic [7:0] invLit [0:2] = '{8'hFE, 8'hFD, 8'hFB};

    dich00_led_shifter #(.STEP_CYCLES(4), .LED_INV(1'b0)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .led   (led4)
    );

    dich00_led_shifter #(.STEP_CYCLES(1), .LED_INV(1'b1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .led   (led1)
    );

    dich00_led_shifter #(.STEP_CYCLES(3), .LED_INV(1'b0)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .led   (led3)
    );

    always #5 clk = ~clk;

    // Reference sequence written straight from the four phase formulas.
    initial begin
        int v;
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 8; i++) begin
                case (ph)
                    0:       v = 1 << i;
                    1:       v = 128 >> i;
                    2:       v = (1 << (i + 1)) - 1;
                    default: v = (255 << (i + 1)) & 255;
                endcase
                refTable[ph * 8 + i] = v[7:0];
            end
        end
    end

    // Rising edges seen since reset was released.
    always @(posedge clk) begin
        if (!rst_n) edgeCount = 0;
        else        edgeCount = edgeCount + 1;
    end

    always @(negedge rst_n) edgeCount = 0;

    function automatic logic [7:0] modelLed(input int edges, input int steps, input bit inv);
        int ticks;
        logic [7:0] p;
        ticks = edges / steps;
        p = (ticks == 0) ? 8'h00 : refTable[(ticks - 1) % 32];
        return inv ? ~p : p;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Continuous comparison of every instance against the model.
    always @(negedge clk) begin
        if (checkEnable) begin
            checkOutput("model_s4", led4, modelLed(edgeCount, 4, 1'b0));
            checkOutput("model_s1_inv", led1, modelLed(edgeCount, 1, 1'b1));
            checkOutput("model_s3", led3, modelLed(edgeCount, 3, 1'b0));
        end
    end

    task automatic applyStimulus(input int runCycles, input int assertDelay, input int holdCycles);
        repeat (runCycles) @(negedge clk);
        #(assertDelay) rst_n = 1'b0;
        #1;
        checkOutput("rand_async_s4", led4, 8'h00);
        checkOutput("rand_async_s1", led1, 8'hFF);
        checkOutput("rand_async_s3", led3, 8'h00);
        repeat (holdCycles) @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int waited;
        rst_n = 1'b0;
        checkEnable = 1'b1;
        $display("[TB] reset hold");
        repeat (5) begin
            @(negedge clk);
            checkOutput("reset_hold", led4, 8'h00);
            checkOutput("reset_hold_inv", led1, 8'hFF);
        end
        #2 rst_n = 1'b1;

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("pre_tick", led4, 8'h00);
            checkOutput("inv_walk", led1, invLit[k]);
        end
        @(negedge clk);
        checkOutput("first_tick", led4, seqLit[0]);

        $display("[TB] full period walk");
        for (int n = 1; n < 33; n++) begin
            repeat (4) @(negedge clk);
            checkOutput("seq_walk", led4, seqLit[n]);
        end

        $display("[TB] async reset during fill");
        waited = 0;
        while (led4 !== 8'h0F && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("wait_fill", led4, 8'h0F);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_s4", led4, 8'h00);
        checkOutput("async_reset_s1", led1, 8'hFF);
        checkOutput("async_reset_s3", led3, 8'h00);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("restart_wait", led4, 8'h00);
        end
        @(negedge clk);
        checkOutput("restart_tick", led4, 8'h01);

        $display("[TB] random reset pulses");
        repeat (12) begin
            applyStimulus($urandom_range(1, 300), $urandom_range(1, 3), $urandom_range(0, 3));
        end

        $display("[TB] long run");
        repeat (4200) @(negedge clk);

        checkEnable = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
